// File: rtl/alarm_pkg.sv
// Shared types and default delays for the alarm timer.
// Interval encodings index the reprogrammable delay table.
package alarm_pkg;

  typedef enum logic [1:0] {
    IV_ARM    = 2'b00,
    IV_DRIVER = 2'b01,
    IV_PASS   = 2'b10,
    IV_SIREN  = 2'b11
  } interval_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] DEF_ARM    = 4'd6;
  localparam logic [3:0] DEF_DRIVER = 4'd8;
  localparam logic [3:0] DEF_PASS   = 4'd15;
  localparam logic [3:0] DEF_SIREN  = 4'd10;

endpackage

// File: rtl/alarm_timer_if.sv
// Control and status bundle of the alarm timer.
// master drives requests, slave is the timer itself.
interface alarm_timer_if;
  import alarm_pkg::*;

  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic       busy;
  logic [3:0] remaining;

  modport master (
    output start_timer, interval,
    output reprogram, param_sel, time_value,
    input  expired, one_hz_enable,
    input  busy, remaining
  );

  modport slave (
    input  start_timer, interval,
    input  reprogram, param_sel, time_value,
    output expired, one_hz_enable,
    output busy, remaining
  );

endinterface

// File: rtl/one_hz_divider.sv
// Free-running prescaler producing a registered one-cycle tick.
// clear restarts the period so the next tick is CLK_HZ cycles away.
module one_hz_divider #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      // a clear suppresses a pulse from the abandoned period
      tick <= (cnt == LAST) && !clear;
      if (clear || cnt == LAST)
        cnt <= '0;
      else
        cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/alarm_timer.sv
// Car alarm interval timer: delay table, one-second prescaler
// and IDLE/COUNT/DONE sequencer with restart on start_timer.
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int         CLK_HZ           = 100000000,
  parameter logic [3:0] T_ARM_DEFAULT    = DEF_ARM,
  parameter logic [3:0] T_DRIVER_DEFAULT = DEF_DRIVER,
  parameter logic [3:0] T_PASS_DEFAULT   = DEF_PASS,
  parameter logic [3:0] T_SIREN_DEFAULT  = DEF_SIREN
) (
  input  logic         clock,
  input  logic         reset,
  alarm_timer_if.slave bus
);

  state_t     state;
  state_t     next_state;
  logic [3:0] remaining_q;
  logic [3:0] next_remaining;
  logic [3:0] times [4];
  logic       tick;

  one_hz_divider #(.CLK_HZ(CLK_HZ)) u_div (
    .clock (clock),
    .reset (reset),
    .clear (bus.start_timer),
    .tick  (tick)
  );

  // zero is not a valid delay, so such writes are dropped
  always_ff @(posedge clock) begin
    if (reset) begin
      times[IV_ARM]    <= T_ARM_DEFAULT;
      times[IV_DRIVER] <= T_DRIVER_DEFAULT;
      times[IV_PASS]   <= T_PASS_DEFAULT;
      times[IV_SIREN]  <= T_SIREN_DEFAULT;
    end else if (bus.reprogram && bus.time_value != 4'd0) begin
      times[bus.param_sel] <= bus.time_value;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      remaining_q <= 4'd0;
    end else begin
      state       <= next_state;
      remaining_q <= next_remaining;
    end
  end

  always_comb begin
    next_state     = state;
    next_remaining = remaining_q;
    if (bus.start_timer) begin
      next_state     = ST_COUNT;
      next_remaining = times[bus.interval];
    end else begin
      unique case (state)
        ST_COUNT: begin
          if (tick) begin
            if (remaining_q <= 4'd1) begin
              next_state     = ST_DONE;
              next_remaining = 4'd0;
            end else begin
              next_remaining = remaining_q - 4'd1;
            end
          end
        end
        ST_DONE: next_state = ST_IDLE;
        default: begin
          next_state     = ST_IDLE;
          next_remaining = 4'd0;
        end
      endcase
    end
  end

  assign bus.expired       = (state == ST_DONE);
  assign bus.busy          = (state != ST_IDLE);
  assign bus.remaining     = remaining_q;
  assign bus.one_hz_enable = tick;

endmodule
